// File: rtl/dmem_arbiter_if.sv
// Port bundle for dmem_arbiter: two requester ports plus the single-port dmem pins.
// slave = arbiter side, master = requesters and memory model side.
interface dmem_arbiter_if;
    logic        p0_req;
    logic        p0_rnw;
    logic [1:0]  p0_size;
    logic [31:0] p0_addr;
    logic [31:0] p0_wdata;
    logic        p0_gnt;
    logic        p0_rvalid;
    logic [31:0] p0_rdata;
    logic        p0_err;

    logic        p1_req;
    logic        p1_rnw;
    logic [1:0]  p1_size;
    logic [31:0] p1_addr;
    logic [31:0] p1_wdata;
    logic        p1_gnt;
    logic        p1_rvalid;
    logic [31:0] p1_rdata;
    logic        p1_err;

    logic        mem_enable;
    logic        mem_rnw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  p0_req, p0_rnw, p0_size, p0_addr, p0_wdata,
        output p0_gnt, p0_rvalid, p0_rdata, p0_err,
        input  p1_req, p1_rnw, p1_size, p1_addr, p1_wdata,
        output p1_gnt, p1_rvalid, p1_rdata, p1_err,
        output mem_enable, mem_rnw, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output p0_req, p0_rnw, p0_size, p0_addr, p0_wdata,
        input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
        output p1_req, p1_rnw, p1_size, p1_addr, p1_wdata,
        input  p1_gnt, p1_rvalid, p1_rdata, p1_err,
        input  mem_enable, mem_rnw, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin two-port sequencer in front of the single-port dmem; sub-word stores
// become read-modify-write pairs, bad requests are answered without touching memory.
module dmem_arbiter #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset_n,
    dmem_arbiter_if.slave        bus,
    output logic                 busy,
    output logic [2:0]           state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_RD     = 3'd1;
    localparam logic [2:0] S_WR     = 3'd2;
    localparam logic [2:0] S_RMW_RD = 3'd3;
    localparam logic [2:0] S_RMW_WR = 3'd4;
    localparam logic [2:0] S_RESP   = 3'd5;

    logic [2:0]  state;
    logic        rr;
    logic        owner;
    logic        l_rnw;
    logic [1:0]  l_size;
    logic [31:0] l_addr;
    logic [31:0] l_wdata;
    logic [31:0] rbuf;
    logic        l_err;

    logic        any_req;
    logic        win;
    logic        accept;
    logic        sel_rnw;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;
    logic        mem_access;
    logic [31:0] merged;
    logic [31:0] shifted;
    logic [31:0] resp_data;

    // Handshake: a requester holds req with stable fields until its gnt pulse; gnt
    // means the fields were latched this cycle. rvalid pulses once per accepted
    // request, carrying rdata/err; there is no back-pressure on the response.
    assign any_req  = bus.p0_req | bus.p1_req;
    assign win      = (bus.p0_req & bus.p1_req) ? rr : bus.p1_req;
    assign accept   = reset_n & (state == S_IDLE) & any_req;

    assign sel_rnw   = win ? bus.p1_rnw   : bus.p0_rnw;
    assign sel_size  = win ? bus.p1_size  : bus.p0_size;
    assign sel_addr  = win ? bus.p1_addr  : bus.p0_addr;
    assign sel_wdata = win ? bus.p1_wdata : bus.p0_wdata;

    assign sel_err = (sel_size == 2'd3)
                   | ((sel_size == 2'd1) & sel_addr[0])
                   | ((sel_size == 2'd2) & (sel_addr[1:0] != 2'b00))
                   | ({2'b00, sel_addr[31:2]} >= 32'(DEPTH_WORDS));

    assign bus.p0_gnt = accept & ~win;
    assign bus.p1_gnt = accept &  win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            rr      <= 1'b0;
            owner   <= 1'b0;
            l_rnw   <= 1'b0;
            l_size  <= 2'd0;
            l_addr  <= 32'd0;
            l_wdata <= 32'd0;
            rbuf    <= 32'd0;
            l_err   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        owner   <= win;
                        rr      <= ~win;
                        l_rnw   <= sel_rnw;
                        l_size  <= sel_size;
                        l_addr  <= sel_addr;
                        l_wdata <= sel_wdata;
                        l_err   <= sel_err;
                        rbuf    <= 32'd0;
                        if (sel_err)                state <= S_RESP;
                        else if (sel_rnw)           state <= S_RD;
                        else if (sel_size == 2'd2)  state <= S_WR;
                        else                        state <= S_RMW_RD;
                    end
                end
                S_RD: begin
                    rbuf  <= bus.mem_rdata;
                    state <= S_RESP;
                end
                S_WR:     state <= S_RESP;
                S_RMW_RD: begin
                    rbuf  <= bus.mem_rdata;
                    state <= S_RMW_WR;
                end
                S_RMW_WR: state <= S_RESP;
                S_RESP:   state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Replace only the addressed lanes of the word fetched in RMW_RD.
    always_comb begin
        merged = rbuf;
        if (l_size == 2'd0) begin
            case (l_addr[1:0])
                2'd0:    merged[7:0]   = l_wdata[7:0];
                2'd1:    merged[15:8]  = l_wdata[7:0];
                2'd2:    merged[23:16] = l_wdata[7:0];
                default: merged[31:24] = l_wdata[7:0];
            endcase
        end else if (l_addr[1]) begin
            merged[31:16] = l_wdata[15:0];
        end else begin
            merged[15:0] = l_wdata[15:0];
        end
    end

    assign mem_access = (state == S_RD) | (state == S_WR)
                      | (state == S_RMW_RD) | (state == S_RMW_WR);

    assign bus.mem_enable = mem_access;
    assign bus.mem_rnw    = ~((state == S_WR) | (state == S_RMW_WR));
    assign bus.mem_addr   = mem_access ? {l_addr[31:2], 2'b00} : 32'd0;

    always_comb begin
        bus.mem_wdata = 32'd0;
        if (state == S_WR)     bus.mem_wdata = l_wdata;
        if (state == S_RMW_WR) bus.mem_wdata = merged;
    end

    assign shifted = rbuf >> {l_addr[1:0], 3'b000};

    always_comb begin
        case (l_size)
            2'd0:    resp_data = {24'd0, shifted[7:0]};
            2'd1:    resp_data = {16'd0, shifted[15:0]};
            default: resp_data = shifted;
        endcase
        if (l_err || !l_rnw) resp_data = 32'd0;
    end

    assign bus.p0_rvalid = (state == S_RESP) & ~owner;
    assign bus.p1_rvalid = (state == S_RESP) &  owner;
    assign bus.p0_rdata  = bus.p0_rvalid ? resp_data : 32'd0;
    assign bus.p1_rdata  = bus.p1_rvalid ? resp_data : 32'd0;
    assign bus.p0_err    = bus.p0_rvalid & l_err;
    assign bus.p1_err    = bus.p1_rvalid & l_err;

    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_dmem_arbiter;

    logic       clk;
    logic       reset_n;
    logic       busy;
    logic [2:0] state_dbg;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH_WORDS(1024)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    function automatic logic [31:0] init_word(input int i);
        return (i == 1) ? 32'h00002222 : (32'hC0DE0000 | 32'(i));
    endfunction

    // ---------------- environment memory ----------------
    logic [31:0] env_mem [0:1023];
    bit          env_loaded = 1'b0;

    assign bus.mem_rdata = env_mem[bus.mem_addr[11:2]];

    always @(posedge clk) begin
        if (!env_loaded) begin
            for (int i = 0; i < 1024; i++) env_mem[i] <= init_word(i);
            env_loaded <= 1'b1;
        end else if (bus.mem_enable && !bus.mem_rnw) begin
            env_mem[bus.mem_addr[11:2]] <= bus.mem_wdata;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct packed {
        logic [31:0] cyc;
        logic        port;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [0:1023];
    bit          ref_loaded = 1'b0;
    int          cyc = 0;
    int          free_cyc = 0;
    int          rr_m = 0;
    int          gnt_log[$];
    int          last_gnt_cyc [2];
    int          last_rv_cyc [2];
    logic [31:0] last_rdata [2];
    logic        last_err [2];
    int          en_cnt = 0;
    int          wr_cnt = 0;
    int          last_wr_cyc = 0;
    logic [31:0] last_wr_addr = 32'd0;
    logic [31:0] last_wr_data = 32'd0;

    task automatic model_txn(input logic rnw, input logic [1:0] size, input logic [31:0] addr,
                             input logic [31:0] wdata, output logic err,
                             output logic [31:0] rdata, output int lat);
        int          nbytes;
        int          sh;
        int          idx;
        logic [31:0] mask;
        nbytes = 1 << int'(size);
        err    = (size == 2'd3) || ((int'(addr[1:0]) % nbytes) != 0) || ((addr >> 2) >= 32'd1024);
        rdata  = 32'd0;
        if (err) begin
            lat = 1;
        end else begin
            idx  = int'(addr >> 2);
            sh   = 8 * int'(addr[1:0]);
            mask = (size == 2'd0) ? 32'h000000FF : (size == 2'd1) ? 32'h0000FFFF : 32'hFFFFFFFF;
            if (rnw) begin
                lat   = 2;
                rdata = (ref_mem[idx] >> sh) & mask;
            end else if (size == 2'd2) begin
                lat          = 2;
                ref_mem[idx] = wdata;
            end else begin
                lat          = 3;
                ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
            end
        end
    endtask

    always @(negedge clk) begin
        int          exp_w;
        logic        m_err;
        logic [31:0] m_rdata;
        int          m_lat;
        exp_t        e;
        cyc++;
        if (!reset_n) begin
            if (!ref_loaded) begin
                for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
                ref_loaded = 1'b1;
            end
            exp_q.delete();
            free_cyc = 0;
            rr_m     = 0;
            chk1("rst_mem_enable", bus.mem_enable, 1'b0);
            chk1("rst_p0_gnt",     bus.p0_gnt,     1'b0);
            chk1("rst_p1_gnt",     bus.p1_gnt,     1'b0);
            chk1("rst_p0_rvalid",  bus.p0_rvalid,  1'b0);
            chk1("rst_p1_rvalid",  bus.p1_rvalid,  1'b0);
            chk1("rst_busy",       busy,           1'b0);
            chk1("rst_state",      state_dbg == 3'd0, 1'b1);
        end else begin
            // memory pin activity
            if (bus.mem_enable) begin
                en_cnt++;
                chk1("mem_addr_align", bus.mem_addr[1:0] == 2'b00, 1'b1);
                if (!bus.mem_rnw) begin
                    wr_cnt++;
                    last_wr_cyc  = cyc;
                    last_wr_addr = bus.mem_addr;
                    last_wr_data = bus.mem_wdata;
                end
            end else begin
                chk1("idle_mem_rnw", bus.mem_rnw, 1'b1);
                chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
            end

            // responses
            if (exp_q.size() > 0 && int'(exp_q[0].cyc) == cyc) begin
                e = exp_q.pop_front();
                chk1("p0_rvalid", bus.p0_rvalid, !e.port);
                chk1("p1_rvalid", bus.p1_rvalid, e.port);
                chk(e.port ? "p1_rdata" : "p0_rdata", e.port ? bus.p1_rdata : bus.p0_rdata, e.rdata);
                chk1(e.port ? "p1_err" : "p0_err", e.port ? bus.p1_err : bus.p0_err, e.err);
            end else begin
                chk1("p0_rvalid_idle", bus.p0_rvalid, 1'b0);
                chk1("p1_rvalid_idle", bus.p1_rvalid, 1'b0);
            end
            if (bus.p0_rvalid) begin last_rv_cyc[0] = cyc; last_rdata[0] = bus.p0_rdata; last_err[0] = bus.p0_err; end
            if (bus.p1_rvalid) begin last_rv_cyc[1] = cyc; last_rdata[1] = bus.p1_rdata; last_err[1] = bus.p1_err; end

            // arbitration
            chk1("busy", busy, cyc < free_cyc);
            exp_w = -1;
            if (cyc >= free_cyc && (bus.p0_req || bus.p1_req))
                exp_w = (bus.p0_req && bus.p1_req) ? rr_m : (bus.p1_req ? 1 : 0);
            chk1("p0_gnt", bus.p0_gnt, exp_w == 0);
            chk1("p1_gnt", bus.p1_gnt, exp_w == 1);
            if (bus.p0_gnt) begin gnt_log.push_back(0); last_gnt_cyc[0] = cyc; end
            if (bus.p1_gnt) begin gnt_log.push_back(1); last_gnt_cyc[1] = cyc; end
            if (exp_w >= 0) begin
                if (exp_w == 0) model_txn(bus.p0_rnw, bus.p0_size, bus.p0_addr, bus.p0_wdata, m_err, m_rdata, m_lat);
                else            model_txn(bus.p1_rnw, bus.p1_size, bus.p1_addr, bus.p1_wdata, m_err, m_rdata, m_lat);
                e.cyc   = 32'(cyc + m_lat);
                e.port  = (exp_w == 1);
                e.err   = m_err;
                e.rdata = m_rdata;
                exp_q.push_back(e);
                free_cyc = cyc + m_lat + 1;
                rr_m     = 1 - exp_w;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_port(input int p, input logic req, input logic rnw, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (p == 0) begin
            bus.p0_req = req; bus.p0_rnw = rnw; bus.p0_size = size; bus.p0_addr = addr; bus.p0_wdata = wdata;
        end else begin
            bus.p1_req = req; bus.p1_rnw = rnw; bus.p1_size = size; bus.p1_addr = addr; bus.p1_wdata = wdata;
        end
    endtask

    // Leaves req high; returns #1 after the edge that latched the request.
    task automatic issue(input int p, input logic rnw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bit got;
        got = 1'b0;
        set_port(p, 1'b1, rnw, size, addr, wdata);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            #1;
            got = (p == 0) ? bus.p0_gnt : bus.p1_gnt;
        end
        if (!got) begin
            n_checks++;
            $display("FAIL gnt_timeout: port %0d addr 0x%08h got no grant", p, addr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic release_port(input int p);
        set_port(p, 1'b0, 1'b1, 2'd2, 32'd0, 32'd0);
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            #1;
            done = (exp_q.size() == 0) && !busy;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: transaction did not complete");
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        int w0;
        int e0;
        reset_n = 1'b0;
        set_port(0, 1'b0, 1'b1, 2'd2, 32'd0, 32'd0);
        set_port(1, 1'b0, 1'b1, 2'd2, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // reset in the middle of a read
        issue(0, 1'b1, 2'd2, 32'h4, 32'd0);
        release_port(0);
        chk1("t1_mem_enable_rd", bus.mem_enable, 1'b1);
        #2 reset_n = 1'b0;
        #1 chk1("t1_mem_enable_async", bus.mem_enable, 1'b0);
        chk1("t1_busy_async", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        issue(0, 1'b1, 2'd2, 32'h4, 32'd0);
        release_port(0);
        wait_done();
        chk("t1_rdata", last_rdata[0], 32'h00002222);
        chk("t1_latency", last_rv_cyc[0] - last_gnt_cyc[0], 2);

        // word store then load
        w0 = wr_cnt;
        issue(0, 1'b0, 2'd2, 32'h8, 32'h12345678);
        release_port(0);
        wait_done();
        chk("t2_write_count", wr_cnt - w0, 1);
        chk("t2_write_addr", last_wr_addr, 32'h8);
        chk("t2_write_data", last_wr_data, 32'h12345678);
        chk("t2_store_latency", last_rv_cyc[0] - last_gnt_cyc[0], 2);
        issue(0, 1'b1, 2'd2, 32'h8, 32'd0);
        release_port(0);
        wait_done();
        chk("t2_rdata", last_rdata[0], 32'h12345678);

        // byte store (read-modify-write) from port 1
        issue(1, 1'b0, 2'd0, 32'h6, 32'h000000AB);
        release_port(1);
        wait_done();
        chk("t3_merge_data", last_wr_data, 32'h00AB2222);
        chk("t3_write_cycle", last_wr_cyc - last_gnt_cyc[1], 2);
        chk("t3_latency", last_rv_cyc[1] - last_gnt_cyc[1], 3);
        chk("t3_mem_word1", env_mem[1], 32'h00AB2222);
        issue(1, 1'b1, 2'd0, 32'h6, 32'd0);
        release_port(1);
        wait_done();
        chk("t3_rdata", last_rdata[1], 32'h000000AB);

        // both ports requesting continuously; pointer must survive idle cycles
        repeat (5) @(posedge clk);
        #1 gnt_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) issue(0, 1'b1, 2'd2, 32'h10 + 32'(4 * i), 32'd0);
                release_port(0);
            end
            begin
                for (int i = 0; i < 4; i++) issue(1, 1'b1, 2'd2, 32'h20 + 32'(4 * i), 32'd0);
                release_port(1);
            end
        join
        wait_done();
        chk("t4_grant_count", gnt_log.size(), 8);
        for (int i = 0; i < gnt_log.size() && i < 8; i++) chk("t4_order", gnt_log[i], i % 2);

        // error cases never reach memory
        e0 = en_cnt;
        issue(0, 1'b1, 2'd1, 32'h3, 32'd0);
        release_port(0);
        wait_done();
        chk1("t5_half_misaligned_err", last_err[0], 1'b1);
        chk("t5_half_latency", last_rv_cyc[0] - last_gnt_cyc[0], 1);
        issue(1, 1'b1, 2'd3, 32'h0, 32'd0);
        release_port(1);
        wait_done();
        chk1("t5_size3_err", last_err[1], 1'b1);
        chk("t5_size3_latency", last_rv_cyc[1] - last_gnt_cyc[1], 1);
        issue(0, 1'b1, 2'd2, 32'h1000, 32'd0);
        release_port(0);
        wait_done();
        chk1("t5_range_err", last_err[0], 1'b1);
        chk("t5_range_rdata", last_rdata[0], 32'd0);
        chk("t5_no_mem_access", en_cnt - e0, 0);
        issue(1, 1'b1, 2'd2, 32'hFFC, 32'd0);
        release_port(1);
        wait_done();
        chk1("t5_last_word_ok", last_err[1], 1'b0);
        chk("t5_last_word_rdata", last_rdata[1], 32'hC0DE03FF);

        // half load from upper lane
        issue(1, 1'b0, 2'd2, 32'h0, 32'hFDFD1111);
        release_port(1);
        wait_done();
        issue(0, 1'b1, 2'd1, 32'h2, 32'd0);
        release_port(0);
        wait_done();
        chk("t6_rdata", last_rdata[0], 32'h0000FDFD);

        for (int i = 0; i < 16; i++) chk("final_mem", env_mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
